// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Instruction fetch / prefetch unit in front of the 2-way I-cache.
//            Owns the fetch PC, issues word reads to the cache (honouring
//            icache_stall), buffers {pc, instruction} pairs in a DEPTH-entry
//            FIFO and hands them to decode over a valid/ready handshake.
//            Redirects flush the FIFO; a redirect arriving while a miss is
//            outstanding parks the target and lets the miss finish first.
// Ports    : clk, proc_reset (async, active-high)
//            icache_read/write/addr/wdata/rdata/stall : cache processor side
//            redirect, redirect_pc                    : pipeline redirect
//            inst_valid/data/pc, inst_ready           : decode handshake
// Options  : IFQ_BYPASS_EN - when defined, a hit into an empty FIFO is
//            presented to decode in the same cycle (0-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        proc_reset,
    output logic        icache_read,
    output logic        icache_write,
    output logic [29:0] icache_addr,
    output logic [31:0] icache_wdata,
    input  logic [31:0] icache_rdata,
    input  logic        icache_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    // PCs are kept as word addresses; the byte-offset bits are always zero.
    logic [29:0]          r_fetch_pc;
    logic [29:0]          r_target;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [29:0]          r_mem_pc   [DEPTH];
    logic [31:0]          r_mem_data [DEPTH];

    logic                 w_push;
    logic                 w_write;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_capture;
    logic                 w_load_pc;
    logic [29:0]          w_new_pc;
    logic                 w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    assign icache_write = 1'b0;
    assign icache_wdata = 32'h0;
    // The address only moves on a push or a redirect load, and neither can
    // happen while a stalled read is outstanding, so the miss address holds.
    assign icache_addr  = r_fetch_pc;

    // ------------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        icache_read  = 1'b0;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_capture    = 1'b0;
        w_load_pc    = 1'b0;
        w_new_pc     = r_fetch_pc;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
                if (redirect) begin
                    w_flush   = 1'b1;
                    w_load_pc = 1'b1;
                    w_new_pc  = redirect_pc[31:2];
                end
            end

            S_FETCH: begin
                // Count can only fall while a miss is pending, so read stays
                // asserted for the whole miss once it has been raised.
                icache_read = (r_count < c_FULL);
                if (redirect) begin
                    w_flush = 1'b1;
                    if (icache_read && icache_stall) begin
                        // Cannot abandon the miss: park the target.
                        w_capture    = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_load_pc = 1'b1;
                        w_new_pc  = redirect_pc[31:2];
                    end
                end else if (icache_read && !icache_stall) begin
                    w_push = 1'b1;
                end
            end

            S_DRAIN: begin
                icache_read = 1'b1;
                if (redirect) begin
                    w_flush   = 1'b1;
                    w_capture = 1'b1;
                end
                if (!icache_stall) begin
                    // Miss word is dropped; the newest target wins.
                    w_state_next = S_FETCH;
                    w_load_pc    = 1'b1;
                    w_new_pc     = redirect ? redirect_pc[31:2] : r_target;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Decode-side presentation
    // ------------------------------------------------------------------------
`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = w_push && (r_count == '0);
    assign inst_valid = (r_count != '0) || w_bypass;
    assign inst_data  = w_bypass ? icache_rdata : r_mem_data[r_rd_ptr];
    assign inst_pc    = w_bypass ? {r_fetch_pc, 2'b00}
                                 : {r_mem_pc[r_rd_ptr], 2'b00};
    // A bypassed word taken by decode never enters the FIFO.
    assign w_write    = w_push && !(w_bypass && inst_ready);
`else
    assign inst_valid = (r_count != '0);
    assign inst_data  = r_mem_data[r_rd_ptr];
    assign inst_pc    = {r_mem_pc[r_rd_ptr], 2'b00};
    assign w_write    = w_push;
`endif

    // A pop coinciding with a redirect is irrelevant: the FIFO is flushed.
    assign w_pop = (r_count != '0) && inst_ready && !redirect;

    // ------------------------------------------------------------------------
    // State, PC and FIFO registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC[31:2];
            r_target   <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= '0;
                r_mem_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;

            if (w_capture) begin
                r_target <= redirect_pc[31:2];
            end

            // Word address increment wraps 0xFFFF_FFFC -> 0 naturally.
            if (w_load_pc) begin
                r_fetch_pc <= w_new_pc;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 30'd1;
            end

            if (w_flush) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_write) begin
                    r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
                    r_mem_data[r_wr_ptr] <= icache_rdata;
                    r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_write, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
